imem_boot_loader: RTL and testbench
===================================

// Module: imem_boot_loader
// PURPOSE
//  Upstream of the instruction memory and the program counter: streams a program image into
//  instruction memory over a valid/ready handshake, holding the CPU in reset until loading ends.
//  Releases the core (cpu_reset low) only after the last word is written; flags overflow.
//  The top-level ORs cpu_reset with the system reset feeding the PC and register file.
// PARAMETERS
//  WORD_W     32  instruction word width
//  DEPTH      64  instruction memory capacity in words (power of 2, >= 2)
//  ADDR_STEP  1   imem_addr increment per word (set 4 for byte-addressed memory)
// PORTS
//  clk         in   1       system clock, rising edge
//  reset       in   1       asynchronous, active-high
//  start       in   1       one-cycle pulse: begin a new load from word 0
//  in_valid    in   1       source has a word on in_data
//  in_data     in   WORD_W  instruction word
//  in_last     in   1       qualifies in_data as final word of the image
//  in_ready    out  1       loader accepts a word this cycle
//  imem_we     out  1       instruction memory write strobe, one cycle per word
//  imem_addr   out  32      write address = word_index * ADDR_STEP
//  imem_wdata  out  WORD_W  write data
//  cpu_reset   out  1       holds the PC and core in reset while high
//  done        out  1       image loaded, core running
//  error       out  1       overflow: image exceeded DEPTH words
//  word_count  out  32      number of words written in the current/last load
// BEHAVIOUR
//  - Reset (async): state=IDLE; in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0,
//    cpu_reset=1, done=0, error=0, word_count=0. Reset mid-load abandons the load;
//    memory contents are not cleared.
//  - FSM states IDLE, LOAD, DONE, ERR; all outputs are registered or decoded from state only.
//  - IDLE: in_ready=0, in_valid ignored. start -> LOAD; index and word_count cleared.
//  - LOAD: in_ready=1. Accept = in_valid & in_ready at edge N. At N+1: imem_we=1,
//    imem_wdata=in_data, imem_addr=index*ADDR_STEP. word_count increments at N+1.
//    Index increments at N+1. Back-to-back accepts give consecutive write cycles.
//    No accept -> imem_we=0. imem_addr/wdata hold their last value.
//  - Accept with in_last=1 -> DONE (the last word is still written at N+1).
//    Single-word image (in_last on first word) is legal.
//  - Accept at index DEPTH-1 with in_last=1 -> DONE (exactly full is legal).
//  - Accept at index DEPTH-1 with in_last=0 -> ERR. That word is still written.
//    No wrap-around: later words are never written over index 0.
//  - start while in LOAD: ignored.
//  - DONE: in_ready=0, done=1, cpu_reset=0 (first low on the cycle after the last imem_we).
//    start -> LOAD: cpu_reset=1 and done=0 from the next edge. Index and count are cleared.
//  - ERR: in_ready=0, error=1, cpu_reset=1, done=0. start -> LOAD clears error, index, count.
//  - start coinciding with an accept is impossible except in LOAD, where start is ignored.
//  - Word/address math: index is ceil(log2(DEPTH))+1 bits wide; imem_addr is zero-extended to 32.
// TESTING
//  1 reset; check all outputs at reset values; in_valid=1 in IDLE -> no imem_we, in_ready=0.
//  2 start; send 3 words back-to-back (0x8B000000, 0xCB000000, 0xF8000000 with last)
//    -> imem_we for 3 consecutive cycles at addr 0,1,2; done=1; cpu_reset=0; word_count=3.
//  3 start; words with in_valid gaps (valid 1,0,0,1,last) -> exactly 2 writes, addr 0 then 1,
//    imem_we low during gaps.
//  4 DEPTH=64: 64 words, last on the 64th -> done. In a separate run, 65 words without
//    last -> 64 writes, error=1 after word 64, cpu_reset stays 1, addr never wraps to 0.
//  5 assert reset after 2 of 5 words -> immediate IDLE, cpu_reset=1, word_count=0.
//    Then start and load 1 word with last -> addr 0 written, done=1.
//  6 from DONE, start -> cpu_reset=1 next cycle; from ERR, start -> error=0, reload
//    succeeds. ADDR_STEP=4: addresses 0,4,8.

Source files
------------

// File: rtl/imem_boot_loader.sv
// Boot loader: streams a program image into instruction memory over valid/ready and holds
// the core in reset until the final word has been written.
module imem_boot_loader #(
  parameter int unsigned WORD_W    = 32,
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned ADDR_STEP = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              in_valid_i,
  input  logic [WORD_W-1:0] in_data_i,
  input  logic              in_last_i,
  output logic              in_ready_o,
  output logic              imem_we_o,
  output logic [31:0]       imem_addr_o,
  output logic [WORD_W-1:0] imem_wdata_o,
  output logic              cpu_reset_o,
  output logic              done_o,
  output logic              error_o,
  output logic [31:0]       word_count_o
);

  localparam int unsigned IdxW = $clog2(DEPTH) + 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(DEPTH - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StDone, StErr} state_e;

  state_e              state_q, state_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [31:0]         cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [31:0]         addr_q, addr_d;
  logic [WORD_W-1:0]   wdata_q, wdata_d;
  logic                cpu_reset_q, cpu_reset_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      StIdle, StDone, StErr: begin
        if (start_i) begin
          state_d = StLoad;
          idx_d   = '0;
          cnt_d   = '0;
        end
      end
      StLoad: begin
        // start is ignored here; in_ready is implied by being in StLoad
        if (in_valid_i) begin
          we_d    = 1'b1;
          addr_d  = 32'(idx_q) * ADDR_STEP;
          wdata_d = in_data_i;
          idx_d   = idx_q + 1'b1;
          cnt_d   = cnt_q + 32'd1;
          if (in_last_i) begin
            state_d = StDone;
          end else if (idx_q == LastIdx) begin
            state_d = StErr;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    // Release the core one cycle after entering DONE so the last write lands first,
    // but re-assert it on the very edge that leaves DONE.
    cpu_reset_d = !((state_q == StDone) && (state_d == StDone));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_reset_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpu_reset_q <= cpu_reset_d;
    end
  end

  assign in_ready_o   = (state_q == StLoad);
  assign error_o      = (state_q == StErr);
  assign imem_we_o    = we_q;
  assign imem_addr_o  = addr_q;
  assign imem_wdata_o = wdata_q;
  assign cpu_reset_o  = cpu_reset_q;
  assign done_o       = ~cpu_reset_q;
  assign word_count_o = cnt_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Randomized self-checking bench for imem_boot_loader; an image-level model predicts the
// writes and final status, a negedge monitor records what the loaders actually did.
module tb_imem_boot_loader;

  localparam int Depth  = 64;
  localparam int Depth4 = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_last = 1'b0;

  logic        in_ready, imem_we, cpu_reset, done, error;
  logic [31:0] imem_addr, imem_wdata, word_count;
  logic        u4_ready, u4_we, u4_cpu_reset, u4_done, u4_error;
  logic [31:0] u4_addr, u4_wdata, u4_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  imem_boot_loader #(.WORD_W(32), .DEPTH(Depth), .ADDR_STEP(1)) u_dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .in_valid_i(in_valid), .in_data_i(in_data),
    .in_last_i(in_last), .in_ready_o(in_ready), .imem_we_o(imem_we), .imem_addr_o(imem_addr),
    .imem_wdata_o(imem_wdata), .cpu_reset_o(cpu_reset), .done_o(done), .error_o(error),
    .word_count_o(word_count)
  );

  imem_boot_loader #(.WORD_W(32), .DEPTH(Depth4), .ADDR_STEP(4)) u_dut4 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .in_valid_i(in_valid), .in_data_i(in_data),
    .in_last_i(in_last), .in_ready_o(u4_ready), .imem_we_o(u4_we), .imem_addr_o(u4_addr),
    .imem_wdata_o(u4_wdata), .cpu_reset_o(u4_cpu_reset), .done_o(u4_done), .error_o(u4_error),
    .word_count_o(u4_count)
  );

  // Write monitor
  int          cyc = 0;
  logic        prev_cr = 1'b1;
  int          fall_cyc = -1;
  int unsigned wr_addr[$];
  logic [31:0] wr_data[$];
  int          wr_cyc[$];
  int unsigned u4_wr_addr[$];

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (imem_we === 1'b1) begin
      wr_addr.push_back(imem_addr);
      wr_data.push_back(imem_wdata);
      wr_cyc.push_back(cyc);
    end
    if (u4_we === 1'b1) u4_wr_addr.push_back(u4_addr);
    if (prev_cr === 1'b1 && cpu_reset === 1'b0) fall_cyc = cyc;
    prev_cr = cpu_reset;
  end

  logic [31:0] preset [3] = '{32'h8B000000, 32'hCB000000, 32'hF8000000};

  // max_gap > 0: random gap 0..max_gap; max_gap < 0: fixed gap of -max_gap before every word.
  task automatic run_image(input int n, input bit has_last, input int max_gap,
                           input int start_at, input bit use_preset);
    logic [31:0] d[$];
    int base, k, got, gap;
    bit ovf;
    for (int i = 0; i < n; i++) d.push_back(use_preset ? preset[i] : $urandom);
    // Image-level model: words accepted until last or capacity, overflow if capacity hit first
    if (has_last) ovf = (n > Depth);
    else          ovf = (n >= Depth);
    k = ovf ? Depth : n;
    base = wr_addr.size();

    start = 1'b1; in_valid = 1'b0; in_last = 1'b0;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || cpu_reset !== 1'b1 || done !== 1'b0 || error !== 1'b0 ||
        word_count !== 32'd0) begin
      errors++;
      $display("FAIL start_state: got ready=%b cpu_reset=%b done=%b error=%b count=%0d, expected 1 1 0 0 0",
               in_ready, cpu_reset, done, error, word_count);
    end

    for (int i = 0; i < n; i++) begin
      if (max_gap > 0) gap = $urandom_range(0, max_gap);
      else             gap = -max_gap;
      repeat (gap) begin
        in_valid = 1'b0; in_last = 1'b0;
        @(negedge clk);
      end
      in_valid = 1'b1; in_data = d[i]; in_last = has_last && (i == n - 1);
      start = (i == start_at);
      @(negedge clk);
      start = 1'b0;
    end
    in_valid = 1'b0; in_last = 1'b0;
    repeat (3) @(negedge clk);

    got = wr_addr.size() - base;
    checks++;
    if (got != k) begin
      errors++;
      $display("FAIL write_count: got %0d writes, expected %0d", got, k);
    end
    for (int j = 0; j < k && j < got; j++) begin
      checks++;
      if (wr_addr[base+j] != j || wr_data[base+j] !== d[j]) begin
        errors++;
        $display("FAIL write_%0d: got addr=%0d data=%h, expected addr=%0d data=%h",
                 j, wr_addr[base+j], wr_data[base+j], j, d[j]);
      end
      if (j > 0 && max_gap <= 0) begin
        checks++;
        if (wr_cyc[base+j] - wr_cyc[base+j-1] != 1 - max_gap) begin
          errors++;
          $display("FAIL write_spacing_%0d: got %0d cycles, expected %0d", j,
                   wr_cyc[base+j] - wr_cyc[base+j-1], 1 - max_gap);
        end
      end
    end
    checks++;
    if (done !== !ovf || error !== ovf || cpu_reset !== ovf || in_ready !== 1'b0 ||
        word_count !== 32'(k)) begin
      errors++;
      $display("FAIL end_state: got done=%b error=%b cpu_reset=%b ready=%b count=%0d, expected %b %b %b 0 %0d",
               done, error, cpu_reset, in_ready, word_count, !ovf, ovf, ovf, k);
    end
    if (!ovf && got == k) begin
      checks++;
      if (fall_cyc != wr_cyc[base+k-1] + 1) begin
        errors++;
        $display("FAIL release_timing: got cpu_reset low at cycle %0d, expected %0d",
                 fall_cyc, wr_cyc[base+k-1] + 1);
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || imem_we !== 1'b0 || imem_addr !== 32'd0 || imem_wdata !== 32'd0 ||
        cpu_reset !== 1'b1 || done !== 1'b0 || error !== 1'b0 || word_count !== 32'd0) begin
      errors++;
      $display("FAIL reset_values: got ready=%b we=%b addr=%h wdata=%h cpu_reset=%b done=%b error=%b count=%0d",
               in_ready, imem_we, imem_addr, imem_wdata, cpu_reset, done, error, word_count);
    end
    rst = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; in_data = $urandom;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (imem_we !== 1'b0 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL idle_ignores_valid: got we=%b ready=%b, expected 0 0", imem_we, in_ready);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset_mid_load;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = $urandom; in_last = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++;
    if (word_count !== 32'd2) begin
      errors++;
      $display("FAIL mid_load_count: got %0d, expected 2", word_count);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (cpu_reset !== 1'b1 || word_count !== 32'd0 || in_ready !== 1'b0 || imem_we !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got cpu_reset=%b count=%0d ready=%b we=%b, expected 1 0 0 0",
               cpu_reset, word_count, in_ready, imem_we);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_image(1, 1'b1, 0, -1, 1'b0);
  endtask

  task automatic test_err_restart;
    run_image(65, 1'b0, 0, -1, 1'b0);
    run_image(4, 1'b1, 0, -1, 1'b0);
  endtask

  task automatic test_addr_step;
    int base4;
    base4 = u4_wr_addr.size();
    run_image(3, 1'b1, 0, -1, 1'b0);
    checks++;
    if (u4_wr_addr.size() - base4 != 3) begin
      errors++;
      $display("FAIL step4_count: got %0d writes, expected 3", u4_wr_addr.size() - base4);
    end else begin
      for (int j = 0; j < 3; j++) begin
        checks++;
        if (u4_wr_addr[base4+j] != 4 * j) begin
          errors++;
          $display("FAIL step4_addr_%0d: got %0d, expected %0d", j, u4_wr_addr[base4+j], 4 * j);
        end
      end
    end
    checks++;
    if (u4_done !== 1'b1 || u4_count !== 32'd3) begin
      errors++;
      $display("FAIL step4_done: got done=%b count=%0d, expected 1 3", u4_done, u4_count);
    end
  endtask

  task automatic test_random;
    int n;
    bit has_last;
    for (int t = 0; t < 8; t++) begin
      has_last = ($urandom_range(0, 3) != 0);
      n = has_last ? $urandom_range(1, Depth + 4) : $urandom_range(Depth, Depth + 4);
      run_image(n, has_last, $urandom_range(1, 3), -1, 1'b0);
    end
  endtask

  initial begin
    test_reset;
    run_image(3, 1'b1, 0, -1, 1'b1);       // back-to-back, then restart from DONE
    run_image(2, 1'b1, -2, -1, 1'b0);      // valid gaps
    run_image(64, 1'b1, 1, -1, 1'b0);      // exactly full
    test_err_restart;                      // overflow, then restart from ERR
    run_image(5, 1'b1, 0, 2, 1'b0);        // start during LOAD ignored
    test_reset_mid_load;
    test_addr_step;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
